sa_read_channel: RTL and testbench
==================================

Name: sa_read_channel

Overview:
- Per-slave read-side arbitration stage, directly downstream of each master's read dispatcher.
- Collects AR requests from MST_AMT dispatchers, round-robin arbitrates, and registers the winner onto the slave AR interface.
- Records grant order in an order FIFO and routes slave R beats back to the owning dispatcher until RLAST.
- One instance per slave port of the interconnect.

Parameters:
- MST_AMT, 2, number of masters/dispatchers
- OUTSTANDING_AMT, 8, max read transactions in flight at the slave (order FIFO depth, power of 2)
- DATA_WIDTH, 32, RDATA width
- ADDR_WIDTH, 32, ARADDR width
- TRANS_MST_ID_W, 5, ARID/RID width
- TRANS_BURST_W, 2, ARBURST width
- TRANS_DATA_LEN_W, 3, ARLEN width
- TRANS_DATA_SIZE_W, 3, ARSIZE width
- TRANS_WR_RESP_W, 2, RRESP width
- MST_ID_W, $clog2(MST_AMT), master index width (minimum 1)

Ports:
- ACLK_i  in  1  clock
- ARESETn_i  in  1  async active-low reset
- dsp_ARID_i  in  TRANS_MST_ID_W*MST_AMT  per-master ARID
- dsp_ARADDR_i  in  ADDR_WIDTH*MST_AMT  per-master ARADDR
- dsp_ARBURST_i  in  TRANS_BURST_W*MST_AMT  per-master ARBURST
- dsp_ARLEN_i  in  TRANS_DATA_LEN_W*MST_AMT  per-master ARLEN
- dsp_ARSIZE_i  in  TRANS_DATA_SIZE_W*MST_AMT  per-master ARSIZE
- dsp_ARVALID_i  in  MST_AMT  per-master ARVALID
- dsp_AR_outst_full_i  in  MST_AMT  dispatcher outstanding-full flag; masks that master's request
- dsp_ARREADY_o  out  MST_AMT  per-master ARREADY
- dsp_RID_o  out  TRANS_MST_ID_W  RID, broadcast to all masters
- dsp_RDATA_o  out  DATA_WIDTH  RDATA, broadcast
- dsp_RRESP_o  out  TRANS_WR_RESP_W  RRESP, broadcast
- dsp_RLAST_o  out  1  RLAST, broadcast
- dsp_RVALID_o  out  MST_AMT  one-hot RVALID to the owning master
- dsp_RREADY_i  in  MST_AMT  per-master RREADY
- s_ARID_o  out  TRANS_MST_ID_W  slave ARID
- s_ARADDR_o  out  ADDR_WIDTH  slave ARADDR
- s_ARBURST_o  out  TRANS_BURST_W  slave ARBURST
- s_ARLEN_o  out  TRANS_DATA_LEN_W  slave ARLEN
- s_ARSIZE_o  out  TRANS_DATA_SIZE_W  slave ARSIZE
- s_ARVALID_o  out  1  slave ARVALID (registered)
- s_ARREADY_i  in  1  slave ARREADY
- s_RID_i  in  TRANS_MST_ID_W  slave RID
- s_RDATA_i  in  DATA_WIDTH  slave RDATA
- s_RRESP_i  in  TRANS_WR_RESP_W  slave RRESP
- s_RLAST_i  in  1  slave RLAST
- s_RVALID_i  in  1  slave RVALID
- s_RREADY_o  out  1  slave RREADY

Behaviour:
- Reset (async, ARESETn_i=0):
  - AR output register empty; s_ARVALID_o=0 and AR payload regs =0.
  - RR pointer = 0, so master 0 has highest priority.
  - Order FIFO empty.
  - All dsp_ARREADY_o, dsp_RVALID_o and s_RREADY_o = 0.
  - Reset mid-burst drops all in-flight state; no recovery is attempted.
- Eligibility: req[i] = dsp_ARVALID_i[i] & ~dsp_AR_outst_full_i[i].
- Load condition: load = (~s_ARVALID_o | s_ARREADY_i) & ~fifo_full_adj.
  - fifo_full_adj = order FIFO full, counting a push pending from the current slave handshake.
- Arbitration:
  - Combinational round-robin. Priority order is ptr, ptr+1, … MST_AMT-1, 0, …, wrapping modulo MST_AMT.
  - Grant g = first eligible master in that order.
  - When load is true and any req[i] is set, dsp_ARREADY_o[g]=1 (one-hot, only to g).
  - On that handshake, g's payload and g's index are latched into the AR register, s_ARVALID_o=1 next cycle, and ptr = g+1 (wrapping).
- AR latency: exactly one cycle from dispatcher handshake to s_ARVALID_o.
  - Back-to-back issue is supported: a register drain and a reload may occur in the same cycle.
- AR hold: payload and s_ARVALID_o stay stable until s_ARREADY_i. No request is ever withdrawn.
- Order FIFO:
  - Push latched master index on s_ARVALID_o & s_ARREADY_i.
  - Pop on R handshake with s_RLAST_i.
  - Simultaneous push and pop when full is allowed: the pop frees the slot, so push proceeds and the count is unchanged.
- R routing:
  - h = FIFO head index.
  - dsp_RVALID_o[h] = s_RVALID_i & ~empty; all other bits 0.
  - s_RREADY_o = dsp_RREADY_i[h] & ~empty.
  - Payload is passed through combinationally (zero latency).
  - FIFO empty gives s_RREADY_o=0; any unexpected slave beat is stalled.
- Multi-beat bursts: the head holds until the RLAST beat handshakes. Beats of different transactions never interleave, because slaves return in order.

Decomposition:
- Shared package/header: MST_ID_W computation, the TRANS_* width defaults, and a round-robin next-pointer function common with the write-side arbiter.
- One natural sub-module: sa_order_fifo, a synchronous FIFO of width MST_ID_W and depth OUTSTANDING_AMT with full/empty flags and async reset.
- The arbiter stays inline.

Test Plan:
- Single master: m0 issues ARID=3, ADDR=0x4000_0010, LEN=3 -> s_ARVALID_o rises 1 cycle later with identical payload; 4 R beats with RLAST on beat 4 -> dsp_RVALID_o=2'b01 on each beat; FIFO empty afterwards.
- Contention: m0 and m1 valid every cycle, slave ARREADY=1 -> grants alternate m0,m1,m0,m1; s_ARVALID_o stays high continuously, one transaction per cycle.
- Masking: dsp_AR_outst_full_i=2'b01 with both valid -> only m1 is granted; dropping full restores m0 priority on the next arbitration.
- Outstanding limit: OUTSTANDING_AMT=8, slave never returns R -> exactly 8 slave AR handshakes, then all dsp_ARREADY_o=0; one RLAST handshake -> exactly one more grant.
- R backpressure: head=m1, dsp_RREADY_i=2'b01 -> s_RREADY_o=0 and RDATA held; raising bit1 completes the beat.
- Reset mid-burst: deassert ARESETn_i during beat 2 of LEN=3 -> all outputs 0 immediately; after release, a fresh m0 request is granted first.

Source files
------------

// File: rtl/sa_read_channel_pkg.sv
// Shared definitions for the slave-side arbitration stages (read and write channels).
package sa_read_channel_pkg;

  localparam int unsigned TRANS_MST_ID_W_DFLT    = 5;
  localparam int unsigned TRANS_BURST_W_DFLT     = 2;
  localparam int unsigned TRANS_DATA_LEN_W_DFLT  = 3;
  localparam int unsigned TRANS_DATA_SIZE_W_DFLT = 3;
  localparam int unsigned TRANS_WR_RESP_W_DFLT   = 2;

  // Master index width; a single master still needs one bit to carry an index.
  function automatic int unsigned mst_id_w(input int unsigned amt);
    return (amt > 1) ? $clog2(amt) : 1;
  endfunction

  // Round-robin pointer after granting g: the next master in wrap-around order.
  function automatic int unsigned rr_next(input int unsigned g, input int unsigned amt);
    return (g + 1 >= amt) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/sa_order_fifo.sv
// Order FIFO holding the owning master index of each read transaction in flight.
module sa_order_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             almost_full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   cnt_q;
  logic             do_push, do_pop;

  assign full_o        = (cnt_q == (PTR_W + 1)'(DEPTH));
  assign almost_full_o = (cnt_q == (PTR_W + 1)'(DEPTH - 1));
  assign empty_o       = (cnt_q == '0);
  assign rdata_o       = mem_q[rptr_q];

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + PTR_W'(1);
      end
      if (do_pop) rptr_q <= rptr_q + PTR_W'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + (PTR_W + 1)'(1);
      else if (!do_push && do_pop) cnt_q <= cnt_q - (PTR_W + 1)'(1);
    end
  end

endmodule

// File: rtl/sa_read_channel.sv
// Per-slave read arbitration: round-robin AR grant into a register slice, in-order R return
// routed to the owning dispatcher via the order FIFO.
module sa_read_channel
  import sa_read_channel_pkg::*;
#(
  parameter int unsigned MST_AMT           = 2,
  parameter int unsigned OUTSTANDING_AMT   = 8,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned ADDR_WIDTH        = 32,
  parameter int unsigned TRANS_MST_ID_W    = TRANS_MST_ID_W_DFLT,
  parameter int unsigned TRANS_BURST_W     = TRANS_BURST_W_DFLT,
  parameter int unsigned TRANS_DATA_LEN_W  = TRANS_DATA_LEN_W_DFLT,
  parameter int unsigned TRANS_DATA_SIZE_W = TRANS_DATA_SIZE_W_DFLT,
  parameter int unsigned TRANS_WR_RESP_W   = TRANS_WR_RESP_W_DFLT,
  parameter int unsigned MST_ID_W          = mst_id_w(MST_AMT)
) (
  input  logic                                  ACLK_i,
  input  logic                                  ARESETn_i,
  input  logic [TRANS_MST_ID_W*MST_AMT-1:0]     dsp_ARID_i,
  input  logic [ADDR_WIDTH*MST_AMT-1:0]         dsp_ARADDR_i,
  input  logic [TRANS_BURST_W*MST_AMT-1:0]      dsp_ARBURST_i,
  input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]   dsp_ARLEN_i,
  input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]  dsp_ARSIZE_i,
  input  logic [MST_AMT-1:0]                    dsp_ARVALID_i,
  input  logic [MST_AMT-1:0]                    dsp_AR_outst_full_i,
  output logic [MST_AMT-1:0]                    dsp_ARREADY_o,
  output logic [TRANS_MST_ID_W-1:0]             dsp_RID_o,
  output logic [DATA_WIDTH-1:0]                 dsp_RDATA_o,
  output logic [TRANS_WR_RESP_W-1:0]            dsp_RRESP_o,
  output logic                                  dsp_RLAST_o,
  output logic [MST_AMT-1:0]                    dsp_RVALID_o,
  input  logic [MST_AMT-1:0]                    dsp_RREADY_i,
  output logic [TRANS_MST_ID_W-1:0]             s_ARID_o,
  output logic [ADDR_WIDTH-1:0]                 s_ARADDR_o,
  output logic [TRANS_BURST_W-1:0]              s_ARBURST_o,
  output logic [TRANS_DATA_LEN_W-1:0]           s_ARLEN_o,
  output logic [TRANS_DATA_SIZE_W-1:0]          s_ARSIZE_o,
  output logic                                  s_ARVALID_o,
  input  logic                                  s_ARREADY_i,
  input  logic [TRANS_MST_ID_W-1:0]             s_RID_i,
  input  logic [DATA_WIDTH-1:0]                 s_RDATA_i,
  input  logic [TRANS_WR_RESP_W-1:0]            s_RRESP_i,
  input  logic                                  s_RLAST_i,
  input  logic                                  s_RVALID_i,
  output logic                                  s_RREADY_o
);

  logic [TRANS_MST_ID_W-1:0]    arid   [MST_AMT];
  logic [ADDR_WIDTH-1:0]        araddr [MST_AMT];
  logic [TRANS_BURST_W-1:0]     arburst[MST_AMT];
  logic [TRANS_DATA_LEN_W-1:0]  arlen  [MST_AMT];
  logic [TRANS_DATA_SIZE_W-1:0] arsize [MST_AMT];

  for (genvar m = 0; m < MST_AMT; m++) begin : g_unpack
    assign arid[m]    = dsp_ARID_i[m*TRANS_MST_ID_W +: TRANS_MST_ID_W];
    assign araddr[m]  = dsp_ARADDR_i[m*ADDR_WIDTH +: ADDR_WIDTH];
    assign arburst[m] = dsp_ARBURST_i[m*TRANS_BURST_W +: TRANS_BURST_W];
    assign arlen[m]   = dsp_ARLEN_i[m*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
    assign arsize[m]  = dsp_ARSIZE_i[m*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
  end

  logic [MST_AMT-1:0]  req;
  logic [MST_ID_W-1:0] ptr_q, gnt_idx, cand, idx_q, head;
  logic                gnt_vld, load, ar_hs, ar_push, r_pop;
  logic                fifo_full, fifo_afull, fifo_empty, fifo_full_adj;

  assign req = dsp_ARVALID_i & ~dsp_AR_outst_full_i;

  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int k = 0; k < MST_AMT; k++) begin
      cand = MST_ID_W'((int'(ptr_q) + k) % MST_AMT);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // The register's pending push is counted so a loaded request always has a FIFO slot.
  assign ar_push       = s_ARVALID_o & s_ARREADY_i;
  assign fifo_full_adj = fifo_full | (fifo_afull & ar_push);
  assign load          = (~s_ARVALID_o | s_ARREADY_i) & ~fifo_full_adj;
  assign ar_hs         = load & gnt_vld;

  always_comb begin
    dsp_ARREADY_o = '0;
    if (ar_hs && ARESETn_i) dsp_ARREADY_o[gnt_idx] = 1'b1;
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      s_ARVALID_o <= 1'b0;
      s_ARID_o    <= '0;
      s_ARADDR_o  <= '0;
      s_ARBURST_o <= '0;
      s_ARLEN_o   <= '0;
      s_ARSIZE_o  <= '0;
      idx_q       <= '0;
      ptr_q       <= '0;
    end else if (ar_hs) begin
      s_ARVALID_o <= 1'b1;
      s_ARID_o    <= arid[gnt_idx];
      s_ARADDR_o  <= araddr[gnt_idx];
      s_ARBURST_o <= arburst[gnt_idx];
      s_ARLEN_o   <= arlen[gnt_idx];
      s_ARSIZE_o  <= arsize[gnt_idx];
      idx_q       <= gnt_idx;
      ptr_q       <= MST_ID_W'(rr_next(32'(gnt_idx), MST_AMT));
    end else if (s_ARREADY_i) begin
      s_ARVALID_o <= 1'b0;
    end
  end

  sa_order_fifo #(
    .WIDTH (MST_ID_W),
    .DEPTH (OUTSTANDING_AMT)
  ) u_order_fifo (
    .clk_i         (ACLK_i),
    .rst_ni        (ARESETn_i),
    .push_i        (ar_push),
    .wdata_i       (idx_q),
    .pop_i         (r_pop),
    .rdata_o       (head),
    .full_o        (fifo_full),
    .almost_full_o (fifo_afull),
    .empty_o       (fifo_empty)
  );

  always_comb begin
    dsp_RVALID_o = '0;
    if (!fifo_empty) dsp_RVALID_o[head] = s_RVALID_i;
  end

  assign s_RREADY_o  = dsp_RREADY_i[head] & ~fifo_empty;
  assign r_pop       = s_RVALID_i & s_RREADY_o & s_RLAST_i;
  assign dsp_RID_o   = s_RID_i;
  assign dsp_RDATA_o = s_RDATA_i;
  assign dsp_RRESP_o = s_RRESP_i;
  assign dsp_RLAST_o = s_RLAST_i;

endmodule

// File: tb/tb_sa_read_channel.sv
// Scoreboard bench for sa_read_channel with two masters and an 8-deep order FIFO.
module tb_sa_read_channel;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]  ar_id;
  logic [63:0] ar_addr;
  logic [3:0]  ar_burst;
  logic [5:0]  ar_len, ar_size;
  logic [1:0]  ar_valid, outst_full, arready, rvalid, rready;
  logic [4:0]  dsp_rid, s_arid, s_rid;
  logic [31:0] dsp_rdata, s_araddr, s_rdata;
  logic [1:0]  dsp_rresp, s_arburst, s_rresp;
  logic [2:0]  s_arlen, s_arsize;
  logic        dsp_rlast, s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;

  sa_read_channel dut (
    .ACLK_i              (clk),
    .ARESETn_i           (rst_n),
    .dsp_ARID_i          (ar_id),
    .dsp_ARADDR_i        (ar_addr),
    .dsp_ARBURST_i       (ar_burst),
    .dsp_ARLEN_i         (ar_len),
    .dsp_ARSIZE_i        (ar_size),
    .dsp_ARVALID_i       (ar_valid),
    .dsp_AR_outst_full_i (outst_full),
    .dsp_ARREADY_o       (arready),
    .dsp_RID_o           (dsp_rid),
    .dsp_RDATA_o         (dsp_rdata),
    .dsp_RRESP_o         (dsp_rresp),
    .dsp_RLAST_o         (dsp_rlast),
    .dsp_RVALID_o        (rvalid),
    .dsp_RREADY_i        (rready),
    .s_ARID_o            (s_arid),
    .s_ARADDR_o          (s_araddr),
    .s_ARBURST_o         (s_arburst),
    .s_ARLEN_o           (s_arlen),
    .s_ARSIZE_o          (s_arsize),
    .s_ARVALID_o         (s_arvalid),
    .s_ARREADY_i         (s_arready),
    .s_RID_i             (s_rid),
    .s_RDATA_i           (s_rdata),
    .s_RRESP_i           (s_rresp),
    .s_RLAST_i           (s_rlast),
    .s_RVALID_i          (s_rvalid),
    .s_RREADY_o          (s_rready)
  );

  typedef struct packed {
    logic [4:0]  id;
    logic [31:0] addr;
    logic [2:0]  len;
  } ar_t;

  typedef struct packed {
    logic [1:0]  onehot;
    logic [31:0] data;
  } r_t;

  ar_t         exp_ar[$];
  r_t          exp_r[$];
  int unsigned own_q[$];
  int          checks = 0;
  int          errors = 0;
  int          ar_slave_hs = 0;

  // Slave-side monitor: every AR and R handshake is scored against the queues.
  always @(negedge clk) begin : monitor
    ar_t e;
    r_t  r;
    if (rst_n && s_arvalid && s_arready) begin
      ar_slave_hs++;
      checks++;
      if (exp_ar.size() == 0) begin
        errors++;
        $display("FAIL ar_unexpected got id=%0h addr=%0h want no transaction", s_arid, s_araddr);
      end else begin
        e = exp_ar.pop_front();
        if ({s_arid, s_araddr, s_arlen, s_arburst, s_arsize} !==
            {e.id, e.addr, e.len, 2'b01, 3'b010}) begin
          errors++;
          $display("FAIL ar_payload got id=%0h addr=%0h len=%0d burst=%0d size=%0d want id=%0h addr=%0h len=%0d burst=1 size=2",
                   s_arid, s_araddr, s_arlen, s_arburst, s_arsize, e.id, e.addr, e.len);
        end
      end
    end
    if (rst_n && s_rvalid && s_rready) begin
      checks++;
      if (exp_r.size() == 0) begin
        errors++;
        $display("FAIL r_unexpected got rvalid=%b data=%0h want no beat", rvalid, dsp_rdata);
      end else begin
        r = exp_r.pop_front();
        if (rvalid !== r.onehot || dsp_rdata !== r.data) begin
          errors++;
          $display("FAIL r_route got rvalid=%b data=%0h want rvalid=%b data=%0h",
                   rvalid, dsp_rdata, r.onehot, r.data);
        end
      end
    end
  end

  task automatic set_req(input int m, input logic [4:0] id, input logic [31:0] addr,
                         input logic [2:0] len);
    ar_id[m*5 +: 5]     = id;
    ar_addr[m*32 +: 32] = addr;
    ar_len[m*3 +: 3]    = len;
    ar_burst[m*2 +: 2]  = 2'b01;
    ar_size[m*3 +: 3]   = 3'b010;
    ar_valid[m]         = 1'b1;
  endtask

  // One arbitration cycle: record dispatcher handshakes, then reload (keep) or drop.
  task automatic ar_cycle(input logic [1:0] keep, output logic [1:0] gnt);
    @(negedge clk);
    gnt = arready;
    for (int m = 0; m < 2; m++) begin
      if (gnt[m] && ar_valid[m]) begin
        exp_ar.push_back('{id: ar_id[m*5 +: 5], addr: ar_addr[m*32 +: 32], len: ar_len[m*3 +: 3]});
        own_q.push_back(m);
      end
    end
    @(posedge clk); #1;
    for (int m = 0; m < 2; m++) begin
      if (gnt[m] && ar_valid[m]) begin
        if (keep[m]) ar_addr[m*32 +: 32] = ar_addr[m*32 +: 32] + 32'h100;
        else ar_valid[m] = 1'b0;
      end
    end
  endtask

  task automatic r_beat(input int owner, input logic [31:0] data, input logic last);
    logic [1:0] oh;
    oh = '0;
    oh[owner] = 1'b1;
    exp_r.push_back('{onehot: oh, data: data});
    s_rvalid = 1'b1;
    s_rdata  = data;
    s_rlast  = last;
    s_rid    = 5'(owner);
    @(negedge clk);
    checks++;
    if (rvalid !== oh || s_rready !== 1'b1) begin
      errors++;
      $display("FAIL r_beat got rvalid=%b rready=%b want rvalid=%b rready=1", rvalid, s_rready, oh);
    end
    @(posedge clk); #1;
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
  endtask

  task automatic drain();
    int unsigned o;
    int n = 0;
    while (own_q.size() > 0) begin
      o = own_q.pop_front();
      r_beat(int'(o), 32'hD000 + 32'(n), 1'b1);
      n++;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    set_req(0, 5'd1, 32'h10, 3'd0);
    set_req(1, 5'd2, 32'h20, 3'd0);
    s_rvalid = 1'b1;
    repeat (2) @(negedge clk);
    checks += 5;
    if (s_arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got %b want 0", s_arvalid); end
    if (arready !== 2'b00) begin errors++; $display("FAIL reset_arready got %b want 00", arready); end
    if (rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b want 00", rvalid); end
    if (s_rready !== 1'b0) begin errors++; $display("FAIL reset_rready got %b want 0", s_rready); end
    if ({s_arid, s_araddr, s_arlen} !== 40'd0) begin
      errors++;
      $display("FAIL reset_payload got %0h want 0", {s_arid, s_araddr, s_arlen});
    end
    @(posedge clk); #1;
    ar_valid = 2'b00;
    s_rvalid = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic test_single();
    logic [1:0] g;
    s_arready = 1'b1;
    set_req(0, 5'd3, 32'h4000_0010, 3'd3);
    ar_cycle(2'b00, g);
    checks++;
    if (g !== 2'b01) begin errors++; $display("FAIL single_gnt got %b want 01", g); end
    @(negedge clk);
    checks++;
    if (s_arvalid !== 1'b1) begin errors++; $display("FAIL single_latency got %b want 1", s_arvalid); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (s_arvalid !== 1'b0) begin errors++; $display("FAIL single_drop got %b want 0", s_arvalid); end
    @(posedge clk); #1;
    void'(own_q.pop_front());
    for (int i = 0; i < 4; i++) r_beat(0, 32'hA000 + 32'(i), (i == 3));
    s_rvalid = 1'b1;
    s_rlast  = 1'b1;
    @(negedge clk);
    checks++;
    if (s_rready !== 1'b0 || rvalid !== 2'b00) begin
      errors++;
      $display("FAIL single_empty_stall got rready=%b rvalid=%b want 0 00", s_rready, rvalid);
    end
    @(posedge clk); #1;
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
  endtask

  task automatic test_contention();
    logic [1:0] g, want;
    int hs0;
    set_req(0, 5'd3, 32'h1000, 3'd0);
    set_req(1, 5'd9, 32'h2000, 3'd0);
    hs0 = ar_slave_hs;
    // Master 0 was granted last, so master 1 leads.
    for (int i = 0; i < 6; i++) begin
      ar_cycle(2'b11, g);
      want = (i % 2 == 0) ? 2'b10 : 2'b01;
      checks++;
      if (g !== want) begin errors++; $display("FAIL contention_gnt%0d got %b want %b", i, g, want); end
    end
    ar_valid = 2'b00;
    idle();
    checks++;
    if (ar_slave_hs - hs0 !== 6) begin
      errors++;
      $display("FAIL contention_rate got %0d slave handshakes want 6", ar_slave_hs - hs0);
    end
    drain();
  endtask

  task automatic test_masking();
    logic [1:0] g;
    set_req(0, 5'd3, 32'h3000, 3'd0);
    set_req(1, 5'd9, 32'h3800, 3'd0);
    outst_full = 2'b01;
    for (int i = 0; i < 3; i++) begin
      ar_cycle(2'b11, g);
      checks++;
      if (g !== 2'b10) begin errors++; $display("FAIL mask_gnt%0d got %b want 10", i, g); end
    end
    outst_full = 2'b00;
    ar_cycle(2'b11, g);
    checks++;
    if (g !== 2'b01) begin errors++; $display("FAIL mask_restore got %b want 01", g); end
    ar_cycle(2'b11, g);
    checks++;
    if (g !== 2'b10) begin errors++; $display("FAIL mask_next got %b want 10", g); end
    ar_valid = 2'b00;
    idle();
    drain();
  endtask

  task automatic test_outstanding();
    logic [1:0] g;
    int hs0, grants;
    int unsigned o;
    set_req(0, 5'd3, 32'h5000, 3'd1);
    hs0 = ar_slave_hs;
    grants = 0;
    for (int i = 0; i < 12; i++) begin
      ar_cycle(2'b01, g);
      if (g[0]) grants++;
    end
    checks += 3;
    if (grants !== 8) begin errors++; $display("FAIL outst_grants got %0d want 8", grants); end
    if (g !== 2'b00) begin errors++; $display("FAIL outst_stall got %b want 00", g); end
    if (ar_slave_hs - hs0 !== 8) begin
      errors++;
      $display("FAIL outst_slave_hs got %0d want 8", ar_slave_hs - hs0);
    end
    o = own_q.pop_front();
    r_beat(int'(o), 32'hC0DE, 1'b1);
    grants = 0;
    for (int i = 0; i < 6; i++) begin
      ar_cycle(2'b01, g);
      if (g[0]) grants++;
    end
    checks++;
    if (grants !== 1) begin errors++; $display("FAIL outst_refill got %0d want 1", grants); end
    ar_valid = 2'b00;
    idle();
    drain();
  endtask

  task automatic test_backpressure();
    logic [1:0] g;
    set_req(1, 5'd9, 32'h6000, 3'd0);
    ar_cycle(2'b00, g);
    checks++;
    if (g !== 2'b10) begin errors++; $display("FAIL bp_gnt got %b want 10", g); end
    idle();
    void'(own_q.pop_front());
    rready   = 2'b01;
    s_rvalid = 1'b1;
    s_rdata  = 32'h55AA;
    s_rlast  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (s_rready !== 1'b0 || rvalid !== 2'b10 || dsp_rdata !== 32'h55AA) begin
        errors++;
        $display("FAIL bp_hold%0d got rready=%b rvalid=%b data=%0h want 0 10 55aa",
                 i, s_rready, rvalid, dsp_rdata);
      end
      @(posedge clk); #1;
    end
    rready = 2'b11;
    r_beat(1, 32'h55AA, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [1:0] g;
    set_req(0, 5'd3, 32'h7000, 3'd3);
    ar_cycle(2'b00, g);
    checks++;
    if (g !== 2'b01) begin errors++; $display("FAIL rmid_gnt got %b want 01", g); end
    idle();
    void'(own_q.pop_front());
    r_beat(0, 32'hB0, 1'b0);
    s_rvalid = 1'b1;
    s_rdata  = 32'hB1;
    set_req(0, 5'd3, 32'h8000, 3'd0);
    set_req(1, 5'd9, 32'h8800, 3'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (s_arvalid !== 1'b0 || arready !== 2'b00 || rvalid !== 2'b00 || s_rready !== 1'b0) begin
      errors++;
      $display("FAIL rmid_outputs got arvalid=%b arready=%b rvalid=%b rready=%b want all 0",
               s_arvalid, arready, rvalid, s_rready);
    end
    exp_ar.delete();
    exp_r.delete();
    own_q.delete();
    @(posedge clk); #1;
    s_rvalid = 1'b0;
    rst_n    = 1'b1;
    ar_cycle(2'b00, g);
    checks++;
    if (g !== 2'b01) begin errors++; $display("FAIL rmid_first got %b want 01", g); end
    ar_cycle(2'b00, g);
    checks++;
    if (g !== 2'b10) begin errors++; $display("FAIL rmid_second got %b want 10", g); end
    idle();
    drain();
  endtask

  initial begin
    ar_id = '0; ar_addr = '0; ar_burst = '0; ar_len = '0; ar_size = '0;
    ar_valid = '0; outst_full = '0; rready = 2'b11;
    s_arready = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_masking();
    test_outstanding();
    test_backpressure();
    test_reset_mid();
    idle();
    checks++;
    if (exp_ar.size() != 0 || exp_r.size() != 0) begin
      errors++;
      $display("FAIL leftover got ar=%0d r=%0d pending want 0 0", exp_ar.size(), exp_r.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no completion want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
